// File: rtl/t_spec_ctrl_pkg.sv
// Shared types and helpers for the branch speculation controller.
package t_spec_ctrl_pkg;

  localparam int unsigned Xlen = 32;

  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic            taken;
    logic [Xlen-1:0] target;
    logic [Xlen-1:0] fallthru;
  } spec_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StFlush
  } spec_state_e;

  // Sequential PC after a control-flow instruction; wraps modulo 2^Xlen.
  function automatic logic [Xlen-1:0] fallthru_pc(input logic [Xlen-1:0] pc, input logic comp);
    return pc + (comp ? Xlen'(2) : Xlen'(4));
  endfunction

endpackage

// File: rtl/t_spec_ctrl_if.sv
// Fetch/execute-side handshake bundle for the speculation controller.
interface t_spec_ctrl_if;
  import t_spec_ctrl_pkg::*;

  logic            pred_valid;
  logic            pred_taken;
  logic [Xlen-1:0] pred_pc;
  logic [Xlen-1:0] pred_target;
  logic            pred_comp;
  logic            res_valid;
  logic            res_taken;
  logic [Xlen-1:0] res_target;
  logic            full;
  logic            spec_hit;
  logic            flush;
  logic [Xlen-1:0] redirect_pc;
  logic            res_err;

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target, pred_comp,
    output res_valid, res_taken, res_target,
    input  full, spec_hit, flush, redirect_pc, res_err
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target, pred_comp,
    input  res_valid, res_taken, res_target,
    output full, spec_hit, flush, redirect_pc, res_err
  );

endinterface

// File: rtl/t_spec_ctrl_fifo.sv
// In-order circular buffer of outstanding predictions with push/pop/clear.
module t_spec_ctrl_fifo
  import t_spec_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  spec_entry_t                entry_i,
  output spec_entry_t                head_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  spec_entry_t      mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/t_spec_ctrl.sv
// Branch speculation tracker: queues predictions, checks them at resolve, flushes on mispredict.
module t_spec_ctrl
  import t_spec_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         stall_i,
  t_spec_ctrl_if.slave bus,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  spec_state_e     state_q, state_d;
  spec_entry_t     head, new_entry;
  logic [CntW-1:0] count;
  logic            full, empty;
  logic            alloc, resolve, hit, push, pop, clear;
  logic            spec_hit_q, flush_q, res_err_q;
  logic [Xlen-1:0] redirect_q;
  logic [31:0]     hit_cnt_q, miss_cnt_q;
  logic            unused_head_pc;

  assign alloc   = bus.pred_valid & ~stall_i & ~full & (state_q != StFlush);
  assign hit     = (head.taken == bus.res_taken) &
                   (~bus.res_taken | (head.target == bus.res_target));
  assign resolve = bus.res_valid & ~empty;
  assign pop     = resolve & hit;
  assign clear   = resolve & ~hit;
  // A mispredict in the same cycle makes the incoming prediction wrong-path.
  assign push    = alloc & ~clear;

  assign new_entry = '{pc:       bus.pred_pc,
                       taken:    bus.pred_taken,
                       target:   bus.pred_target,
                       fallthru: fallthru_pc(bus.pred_pc, bus.pred_comp)};

  t_spec_ctrl_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clear),
    .entry_i (new_entry),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign unused_head_pc = ^head.pc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (push) state_d = StTrack;
      StTrack: begin
        if (clear) begin
          state_d = StFlush;
        end else if (pop && !push && count == CntW'(1)) begin
          state_d = StIdle;
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      spec_hit_q <= 1'b0;
      flush_q    <= 1'b0;
      res_err_q  <= 1'b0;
      redirect_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      spec_hit_q <= pop;
      flush_q    <= clear;
      res_err_q  <= bus.res_valid & empty;
      redirect_q <= clear ? (bus.res_taken ? bus.res_target : head.fallthru) : '0;
      if (pop)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (clear) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.full        = full;
  assign bus.spec_hit    = spec_hit_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.res_err     = res_err_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

endmodule

// File: tb/tb_t_spec_ctrl.sv
// Bench for t_spec_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_t_spec_ctrl;
  localparam int unsigned Depth = 4;

  logic        clk_i;
  logic        rst_ni;
  logic        stall_i;
  logic [31:0] hit_cnt_o, miss_cnt_o;

  t_spec_ctrl_if bus ();

  t_spec_ctrl #(
    .Depth (Depth)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .stall_i    (stall_i),
    .bus        (bus),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] fall;
  } m_ent_t;

  m_ent_t      mq[$];
  logic [31:0] m_hits, m_misses;
  logic        m_flush_blk;
  logic        exp_hit, exp_flush, exp_err;
  logic [31:0] exp_redir;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_hits = 0;
    m_misses = 0;
    m_flush_blk = 1'b0;
  endtask

  // What the controller must do with this cycle's inputs, from the behavioural rules.
  task automatic model_step(input logic pv, pt, input logic [31:0] pc, tgt, input logic cp,
                            input logic rv, rt, input logic [31:0] rtg, input logic st);
    logic   alloc, miss;
    m_ent_t h;
    alloc = pv && !st && (mq.size() != Depth) && !m_flush_blk;
    miss = 1'b0;
    exp_hit = 1'b0;
    exp_flush = 1'b0;
    exp_err = 1'b0;
    exp_redir = 32'h0;
    if (rv) begin
      if (mq.size() == 0) begin
        exp_err = 1'b1;
      end else begin
        h = mq[0];
        if (h.taken == rt && (!rt || h.target == rtg)) begin
          exp_hit = 1'b1;
          m_hits = m_hits + 1;
          void'(mq.pop_front());
        end else begin
          miss = 1'b1;
          exp_flush = 1'b1;
          exp_redir = rt ? rtg : h.fall;
          m_misses = m_misses + 1;
          mq.delete();
        end
      end
    end
    if (alloc && !miss) mq.push_back('{taken: pt, target: tgt, fall: pc + (cp ? 32'd2 : 32'd4)});
    m_flush_blk = miss;
  endtask

  task automatic cycle(input logic pv, pt, input logic [31:0] pc, tgt, input logic cp,
                       input logic rv, rt, input logic [31:0] rtg, input logic st);
    @(negedge clk_i);
    bus.pred_valid = pv;
    bus.pred_taken = pt;
    bus.pred_pc = pc;
    bus.pred_target = tgt;
    bus.pred_comp = cp;
    bus.res_valid = rv;
    bus.res_taken = rt;
    bus.res_target = rtg;
    stall_i = st;
    #1;
    chk("full", 32'(bus.full), 32'(mq.size() == Depth));
    model_step(pv, pt, pc, tgt, cp, rv, rt, rtg, st);
    @(posedge clk_i);
    #1;
    chk("spec_hit", 32'(bus.spec_hit), 32'(exp_hit));
    chk("flush", 32'(bus.flush), 32'(exp_flush));
    chk("res_err", 32'(bus.res_err), 32'(exp_err));
    if (exp_flush) chk("redirect_pc", bus.redirect_pc, exp_redir);
    chk("hit_cnt", hit_cnt_o, m_hits);
    chk("miss_cnt", miss_cnt_o, m_misses);
  endtask

  task automatic alloc_cyc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                           input logic cp);
    cycle(1'b1, pt, pc, tgt, cp, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic res_cyc(input logic rt, input logic [31:0] rtg);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, rt, rtg, 1'b0);
  endtask

  task automatic idle_cyc();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_full"}, 32'(bus.full), 32'h0);
    chk({tag, "_spec_hit"}, 32'(bus.spec_hit), 32'h0);
    chk({tag, "_flush"}, 32'(bus.flush), 32'h0);
    chk({tag, "_res_err"}, 32'(bus.res_err), 32'h0);
    chk({tag, "_redirect"}, bus.redirect_pc, 32'h0);
    chk({tag, "_hit_cnt"}, hit_cnt_o, 32'h0);
    chk({tag, "_miss_cnt"}, miss_cnt_o, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    bus.pred_valid = 1'b0;
    bus.res_valid = 1'b0;
    stall_i = 1'b0;
    #1;
    chk_zero("reset");
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int sum;
    rst_ni = 1'b1;
    stall_i = 1'b0;
    bus.pred_valid = 1'b0;
    bus.pred_taken = 1'b0;
    bus.pred_pc = 32'h0;
    bus.pred_target = 32'h0;
    bus.pred_comp = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_taken = 1'b0;
    bus.res_target = 32'h0;
    model_reset();

    // 1: correct taken prediction
    do_reset();
    alloc_cyc(32'h8000_0000, 1'b1, 32'h8000_0040, 1'b0);
    res_cyc(1'b1, 32'h8000_0040);
    chk("t1_hit_pulse", 32'(bus.spec_hit), 32'h1);
    chk("t1_hit_cnt", hit_cnt_o, 32'd1);
    idle_cyc();
    chk("t1_pulse_end", 32'(bus.spec_hit), 32'h0);
    res_cyc(1'b1, 32'h8000_0040);
    chk("t1_empty", 32'(bus.res_err), 32'h1);

    // 2: compressed taken predicted, resolves not-taken
    do_reset();
    alloc_cyc(32'h100, 1'b1, 32'h180, 1'b1);
    res_cyc(1'b0, 32'h0);
    chk("t2_flush", 32'(bus.flush), 32'h1);
    chk("t2_redirect", bus.redirect_pc, 32'h102);
    chk("t2_miss_cnt", miss_cnt_o, 32'd1);

    // 3: fill, overflow attempt, drain
    do_reset();
    for (int i = 0; i < 4; i++) alloc_cyc(32'h10 * (i + 1), 1'b0, 32'h0, 1'b0);
    chk("t3_full", 32'(bus.full), 32'h1);
    alloc_cyc(32'h50, 1'b0, 32'h0, 1'b0);
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      res_cyc(1'b0, 32'h0);
      sum += int'(bus.spec_hit);
    end
    chk("t3_pulses", 32'(sum), 32'd4);
    chk("t3_hit_cnt", hit_cnt_o, 32'd4);
    chk("t3_not_full", 32'(bus.full), 32'h0);
    res_cyc(1'b0, 32'h0);
    chk("t3_fifth_dropped", 32'(bus.res_err), 32'h1);

    // 4: miss with simultaneous alloc, then blocked alloc during flush
    do_reset();
    alloc_cyc(32'h10, 1'b0, 32'h0, 1'b0);
    alloc_cyc(32'h20, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0);
    chk("t4_flush", 32'(bus.flush), 32'h1);
    chk("t4_redirect", bus.redirect_pc, 32'h500);
    alloc_cyc(32'h40, 1'b0, 32'h0, 1'b0);
    chk("t4_flush_1cyc", 32'(bus.flush), 32'h0);
    res_cyc(1'b0, 32'h0);
    chk("t4_queue_empty", 32'(bus.res_err), 32'h1);
    alloc_cyc(32'h60, 1'b0, 32'h0, 1'b0);
    res_cyc(1'b0, 32'h0);
    chk("t4_idle_alloc", 32'(bus.spec_hit), 32'h1);

    // 5: resolve with empty queue
    do_reset();
    res_cyc(1'b1, 32'h1234);
    chk("t5_err", 32'(bus.res_err), 32'h1);
    chk("t5_hits", hit_cnt_o, 32'h0);
    chk("t5_misses", miss_cnt_o, 32'h0);

    // 6: wrong target, then async reset while flush is high
    do_reset();
    alloc_cyc(32'h80, 1'b1, 32'h200, 1'b0);
    res_cyc(1'b1, 32'h300);
    chk("t6_flush", 32'(bus.flush), 32'h1);
    chk("t6_redirect", bus.redirect_pc, 32'h300);
    #2 rst_ni = 1'b0;
    #1;
    chk_zero("t6_async");
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Random traffic, resolves biased toward the model's head entry
    for (int i = 0; i < 3000; i++) begin
      logic        pv, pt, cp, rv, rt, st;
      logic [31:0] pc, tg, rtg;
      pv = ($urandom_range(0, 99) < 55);
      pt = 1'($urandom_range(0, 1));
      cp = 1'($urandom_range(0, 1));
      pc = 32'($urandom_range(0, 1023)) << 1;
      tg = 32'($urandom_range(1, 3)) << 8;
      rv = ($urandom_range(0, 99) < 40);
      st = ($urandom_range(0, 99) < 15);
      if (mq.size() > 0 && $urandom_range(0, 99) < 70) begin
        rt = mq[0].taken;
        rtg = rt ? mq[0].target : 32'($urandom_range(1, 3)) << 8;
      end else begin
        rt = 1'($urandom_range(0, 1));
        rtg = 32'($urandom_range(1, 3)) << 8;
      end
      cycle(pv, pt, pc, tg, cp, rv, rt, rtg, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
